// File: rtl/hex_scan_display.sv
// Time-multiplexed hex display driver: prescaled digit scan, frame-synchronous shadow load,
// leading-zero blanking and enable gate. Define HEX_SCAN_DP_EN to add per-digit decimal points.
module hex_scan_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int CNT_W    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  blank_en,
    input  logic                  enable,
`ifdef HEX_SCAN_DP_EN
    input  logic [DIGITS-1:0]     dp,
    output logic                  dp_out,
`endif
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_p0;
    logic [IDX_W-1:0]    idx_p0;
    logic [4*DIGITS-1:0] shadow_p0;
    logic                pending_p0;
`ifdef HEX_SCAN_DP_EN
    logic [DIGITS-1:0]   dp_shadow_p0;
    logic                cur_dp;
`endif

    logic                advance;
    logic                wrap;
    logic                take;
    logic [3:0]          cur_nib;
    logic                blank;
    logic                zero_above;
    logic [DIGITS-1:0]   an_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    assign advance = enable && (cnt_p0 == CNT_LAST);
    assign wrap    = advance && (idx_p0 == IDX_LAST);
    // A load seen on the wrap cycle itself is taken without going through pending.
    assign take    = wrap && (pending_p0 || load);

    // Digit select; zero_above accumulates from the top nibble down to the selected digit.
    always_comb begin
        zero_above = 1'b1;
        blank      = 1'b0;
        cur_nib    = 4'h0;
        an_next    = '0;
`ifdef HEX_SCAN_DP_EN
        cur_dp     = 1'b0;
`endif
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (shadow_p0[4*k +: 4] == 4'h0);
            if (idx_p0 == IDX_W'(k)) begin
                cur_nib    = shadow_p0[4*k +: 4];
                blank      = blank_en && (k != 0) && zero_above;
                an_next[k] = 1'b1;
`ifdef HEX_SCAN_DP_EN
                cur_dp     = dp_shadow_p0[k];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0       <= '0;
            idx_p0       <= '0;
            shadow_p0    <= '0;
            pending_p0   <= 1'b0;
            seg          <= '0;
            an           <= '0;
            frame_tick   <= 1'b0;
`ifdef HEX_SCAN_DP_EN
            dp_shadow_p0 <= '0;
            dp_out       <= 1'b0;
`endif
        end else begin
            // p0: scan position and shadow capture
            if (enable) begin
                if (advance) begin
                    cnt_p0 <= '0;
                    idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
                end else begin
                    cnt_p0 <= cnt_p0 + 1'b1;
                end
            end
            if (take) begin
                shadow_p0    <= value;
                pending_p0   <= 1'b0;
`ifdef HEX_SCAN_DP_EN
                dp_shadow_p0 <= dp;
`endif
            end else if (load) begin
                pending_p0   <= 1'b1;
            end
            // p1: registered pin drive
            frame_tick <= wrap;
            seg        <= (enable && !blank) ? hex_to_seg(cur_nib) : 7'b0000000;
            an         <= enable ? an_next : '0;
`ifdef HEX_SCAN_DP_EN
            dp_out     <= enable && cur_dp;
`endif
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display (DIGITS=4, SCAN_DIV=4): per-cycle expected pin states
// are queued by the stimulus process and compared by an independent monitor on the falling edge.
module tb_hex_scan_display;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int CNT_W    = 2;

  localparam logic [6:0] Z  = 7'h7E;
  localparam logic [6:0] S1 = 7'h30;
  localparam logic [6:0] S2 = 7'h6D;
  localparam logic [6:0] S3 = 7'h79;
  localparam logic [6:0] S4 = 7'h33;
  localparam logic [6:0] S5 = 7'h5B;
  localparam logic [6:0] SA = 7'h77;
  localparam logic [6:0] SF = 7'h47;
  localparam logic [6:0] BL = 7'h00;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic [15:0] value    = 16'h0000;
  logic        load     = 1'b0;
  logic        blank_en = 1'b0;
  logic        enable   = 1'b1;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;
`ifdef HEX_SCAN_DP_EN
  logic [3:0]  dp = 4'b0000;
  logic        dp_out;
`endif

  hex_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .blank_en   (blank_en),
    .enable     (enable),
`ifdef HEX_SCAN_DP_EN
    .dp         (dp),
    .dp_out     (dp_out),
`endif
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [3:0] an;
    logic [6:0] seg;
    logic       ft;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   pushed      = 0;
  int   miscompares = 0;

  task automatic push(input int t, input logic [3:0] a, input logic [6:0] s, input logic f);
    exp_t e;
    e.t = t; e.an = a; e.seg = s; e.ft = f;
    sb.push_back(e);
    pushed++;
  endtask

  task automatic push_frame(input int c0, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int m = 0; m < 16; m++)
      push(c0 + m, 4'b0001 << (m / 4), s[m / 4], m == 15);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulse_load(input int n, input logic [15:0] v);
    wait_until(n);
    value = v;
    load  = 1'b1;
    wait_until(n + 1);
    load  = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].t < cyc) begin
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missed_slot t=%0d", e.t);
    end
    if (sb.size() > 0 && sb[0].t == cyc) begin
      e = sb.pop_front();
      vectors++;
      if (an !== e.an || seg !== e.seg || frame_tick !== e.ft) begin
        miscompares++;
        $display("FAIL pins t=%0d got an=%b seg=%b tick=%b want an=%b seg=%b tick=%b",
                 cyc, an, seg, frame_tick, e.an, e.seg, e.ft);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d pending_expectations=%0d", cyc, sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    int n, c0, c1, c2, k;
    @(negedge clk);
    if (an !== 4'b0000 || seg !== 7'b0000000 || frame_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold an=%b seg=%b tick=%b", an, seg, frame_tick);
    end
    @(negedge clk);
    n = cyc;
    push(n + 1, 4'b0000, BL, 1'b0);
    push(n + 2, 4'b0000, BL, 1'b0);
    wait_until(n + 2);
    rst_n = 1'b1;
    c0 = cyc + 1;

    // Power-up frames show 0000; a mid-frame load lands at the next frame boundary.
    push_frame(c0,      Z, Z, Z, Z);
    push_frame(c0 + 16, Z, Z, Z, Z);
    push_frame(c0 + 32, SF, S3, SA, S1);
    pulse_load(c0 + 21, 16'h1A3F);

    // Two loads in one frame, then a load on the wrap cycle, then blanking.
    wait_until(c0 + 40);
    push_frame(c0 + 48, SF, S3, SA, S1);
    push_frame(c0 + 64, S2, S2, S2, S2);
    push_frame(c0 + 80, Z, S4, BL, BL);
    push_frame(c0 + 96, Z, BL, BL, BL);
    pulse_load(c0 + 51, 16'h1111);
    pulse_load(c0 + 57, 16'h2222);
    pulse_load(c0 + 78, 16'h0040);
    blank_en = 1'b1;
    pulse_load(c0 + 82, 16'h0000);

    // Frame with a 10-cycle disable inside digit 1.
    for (int m = 0; m < 26; m++) begin
      if (m >= 6 && m < 16) begin
        push(c0 + 112 + m, 4'b0000, BL, 1'b0);
      end else begin
        k = (m < 6) ? m : m - 10;
        push(c0 + 112 + m, 4'b0001 << (k / 4), (k < 4) ? S5 : Z, k == 15);
      end
    end
    pulse_load(c0 + 100, 16'h0005);
    wait_until(c0 + 111);
    blank_en = 1'b0;
    wait_until(c0 + 117);
    enable = 1'b0;
    wait_until(c0 + 127);
    enable = 1'b1;

    // Reset mid-frame with a load pending: shadow clears and the pending load is dropped.
    c1 = c0 + 138;
    c2 = c1 + 11;
    for (int m = 0; m < 11; m++) begin
      if (m < 7)
        push(c1 + m, 4'b0001 << (m / 4), (m < 4) ? S5 : Z, 1'b0);
      else
        push(c1 + m, 4'b0000, BL, 1'b0);
    end
    push_frame(c2,      Z, Z, Z, Z);
    push_frame(c2 + 16, Z, Z, Z, Z);
    pulse_load(c1 + 3, 16'hBEEF);
    wait_until(c1 + 6);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    if (an !== 4'b0000 || seg !== 7'b0000000 || frame_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset an=%b seg=%b tick=%b", an, seg, frame_tick);
    end
    wait_until(c1 + 10);
    rst_n = 1'b1;

    wait_until(c2 + 34);
    if (vectors != pushed) begin
      miscompares++;
      $display("FAIL vector_count applied=%0d queued=%0d", vectors, pushed);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares != 0)
      $display("FAIL %0d miscompares", miscompares);
    else
      $display("PASS");
    $finish;
  end

endmodule

// File: doc/hex_scan_display.md
Name: hex_scan_display

Overview:
- Parametrised, time-multiplexed hex display driver; successor to the single-digit combinational hex-to-7-segment decoder.
- Drives DIGITS common-segment 7-segment digits from one shared segment bus, scanning one digit at a time.
- Adds a prescaled scan counter, frame-synchronous shadow loading, leading-zero blanking and a display-enable gate.
- Sits between datapath registers and the board's display pins.

Parameters:
- DIGITS, 4, number of hex digits scanned; legal range 1..8.
- SCAN_DIV, 1000, clock cycles each digit stays lit; legal values >= 1.
- CNT_W, 10, prescaler width; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- value  in  4*DIGITS  hex nibbles; nibble i = value[4i+3:4i]; digit 0 is least significant.
- load  in  1  request to capture value into the shadow register.
- blank_en  in  1  1 = blank leading zero digits.
- enable  in  1  0 = all digits dark.
- seg  out  7  segments {a,b,c,d,e,f,g}, a = MSB, active-high, registered.
- an  out  DIGITS  one-hot digit enable, bit i = digit i, active-high, registered.
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0, registered.

Behaviour:
- Reset (async assert, sync release): prescaler=0, idx=0, shadow=0, pending=0, seg=0, an=0, frame_tick=0.
- Prescaler counts 0..SCAN_DIV-1 while enable=1. At terminal count it returns to 0 and advance=1.
- On advance, idx increments; it wraps from DIGITS-1 to 0. At the wrap, wrap=1.
- SCAN_DIV=1: advance every cycle.
- DIGITS=1: idx stays 0 and wrap=advance.
- load=1 sets pending. On wrap, if pending or load is set:
  - shadow <= the value present in that cycle;
  - pending <= 0.
  - A load on the wrap cycle itself is taken directly.
  - Several loads within one frame: the last value wins.
  - The display never shows a mix of two values within one frame.
- Segment decode of the nibble shadow[idx]:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Blanking: with blank_en=1, digit i>0 is blanked when nibbles DIGITS-1 down to i are all zero. Digit 0 is never blanked.
- A blanked digit drives seg=0; an still pulses with its one-hot bit.
- Output latency: seg and an are registered from the current idx and shadow, so they lag idx by 1 cycle.
- frame_tick asserts the cycle after wrap and lasts 1 cycle.
- enable=0:
  - prescaler and idx hold; pending still captures load;
  - seg=0 and an=0 from the next cycle; frame_tick=0.
  - On re-enable, scanning resumes from the held idx and prescaler.
- Reset mid-frame: all state clears immediately, and any pending load is discarded.

Optional Feature:
- Macro: HEX_SCAN_DP_EN.
- Defined: adds input dp [DIGITS-1:0] and output dp_out (1 bit, registered, active-high).
  - dp is captured into a shadow register alongside value, using the same load/wrap rule.
  - dp_out = dp_shadow[idx], with the same latency as seg and forced to 0 when enable=0.
  - dp_out is not affected by blanking. Reset value 0.
- Not defined: the dp and dp_out ports and their logic are absent; all other behaviour is identical.

Test Plan (DIGITS=4, SCAN_DIV=4):
- Reset release, enable=1, no load -> an sequence 0001,0010,0100,1000 repeats, each held 4 cycles. seg=1111110 on every digit. frame_tick pulses once every 16 cycles.
- load value=16'h1A3F mid-frame -> display unchanged until the wrap. Next frame shows seg F=1000111, 3=1111001, A=1110111, 1=0110000 on digits 0..3.
- blank_en=1, load value=16'h0040 -> digits 3 and 2 have seg=0000000; digit 1 shows 0110011; digit 0 shows 1111110. With value=0, only digit 0 is lit, showing 1111110.
- Two loads in one frame (16'h1111, then 16'h2222), and a separate load asserted exactly on the wrap cycle -> the next frame shows 2222 only. The wrap-cycle load value appears in the immediately following frame.
- enable=0 for 10 cycles mid-digit, then enable=1 -> an=0, seg=0, no frame_tick while disabled. Scanning resumes at the same digit with the remaining prescaler count.
- rst_n pulsed low mid-frame after a pending load -> outputs go to 0 immediately; after release the display shows 0000 and the pending value is lost.
